// File: rtl/cmd_frame_ctrl_pkg.sv
// Shared constants and helpers for the command frame sequencer.
//   FRAME_LEN   bytes per command frame
//   ACK_OK/ERR  first acknowledge byte for good/bad frames
//   OP_*        opcode values carried in frame byte 2
//   state_e     sequencer FSM states
//   frame_t     packed 8-byte frame buffer, index = byte position
package cmd_frame_ctrl_pkg;

  localparam int         FRAME_LEN = 8;
  localparam int         NUM_CPU   = 2;   // reset channels: 0 = CPU A, 1 = CPU B

  localparam logic [7:0] ACK_OK    = 8'h5A;
  localparam logic [7:0] ACK_ERR   = 8'hA5;

  localparam logic [7:0] OP_MAN_A  = 8'h01;
  localparam logic [7:0] OP_MAN_B  = 8'h02;
  localparam logic [7:0] OP_RST_A  = 8'h03;
  localparam logic [7:0] OP_RST_B  = 8'h04;
  localparam logic [7:0] OP_AUTO   = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_GAP,
    S_CHECK,
    S_EXEC,
    S_ACK
  } state_e;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  // Checksum covers opcode and the four argument bytes, 8-bit wrap.
  function automatic logic [7:0] frame_sum(input frame_t f);
    logic [7:0] s;
    s = '0;
    for (int i = 2; i < FRAME_LEN-1; i++) s = s + f[i];
    return s;
  endfunction

  function automatic logic op_valid(input logic [7:0] op);
    return (op >= OP_MAN_A) && (op <= OP_AUTO);
  endfunction

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// Byte streams around the sequencer.
//   com_count/rec_command/com_pop : selected comm-port UART receive FIFO
//   tdr_cpuAB/tf_push_cpuAB       : acknowledge bytes to both CPU UART TX FIFOs
// master = sequencer side, slave = UART side.
interface cmd_frame_ctrl_if #(
  parameter int CNT_W = 5
);
  logic [CNT_W-1:0] com_count;
  logic [7:0]       rec_command;
  logic             com_pop;
  logic [7:0]       tdr_cpuAB;
  logic             tf_push_cpuAB;

  modport master (
    input  com_count, rec_command,
    output com_pop, tdr_cpuAB, tf_push_cpuAB
  );

  modport slave (
    output com_count, rec_command,
    input  com_pop, tdr_cpuAB, tf_push_cpuAB
  );
endinterface

// File: rtl/cmd_frame_ctrl_rst_pulse_gen.sv
// Fixed-width reset pulse generator, one per CPU.
//   clk, rst : clock, synchronous active-high reset
//   load     : (re)start a pulse of RST_CYC cycles; re-load restarts, never sums
//   pulse    : high while the down-counter is non-zero
module rst_pulse_gen #(
  parameter logic [15:0] RST_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic pulse
);
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= RST_CYC;
    else if (cnt != '0)   cnt <= cnt - 16'd1;
  end

  assign pulse = (cnt != '0);
endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command sequencer for the dual-CPU switch core.
// Drains 8-byte frames (HDR0 HDR1 op arg0..arg3 csum) from the selected receive
// FIFO, validates them, drives switch-control levels and CPU reset pulses, and
// answers every framed command with a 2-byte acknowledge.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : FIFO pop side + acknowledge push side (master modport)
//   force_swi  : 1 = manual switch mode
//   com_swi    : manual target, 0 = CPU A, 1 = CPU B
//   reset_A/B  : RST_CYC-cycle reset pulses
//   error      : sticky bad-frame flag, cleared by the next good frame
module cmd_frame_ctrl
  import cmd_frame_ctrl_pkg::*;
#(
  parameter int          CNT_W   = 5,
  parameter logic [7:0]  HDR0    = 8'hEB,
  parameter logic [7:0]  HDR1    = 8'h90,
  parameter logic [15:0] RST_CYC = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  cmd_frame_ctrl_if.master  bus,
  output logic              force_swi,
  output logic              com_swi,
  output logic              reset_A,
  output logic              reset_B,
  output logic              error
);

  state_e                 state;
  logic [2:0]             idx;      // byte position being popped
  frame_t                 frm;
  logic                   ack_sel;  // 0 = first ACK byte on the bus, 1 = second
  logic                   frame_good;
  logic [7:0]             opcode;
  logic [NUM_CPU-1:0]     ld;
  logic [NUM_CPU-1:0]     pulse;

  assign opcode     = frm[2];
  assign frame_good = (frm[0] == HDR0) && (frm[1] == HDR1) &&
                      (frame_sum(frm) == frm[FRAME_LEN-1]) && op_valid(opcode);

  // Loading on the EXEC exit edge makes the pulse visible the cycle after EXEC.
  assign ld[0] = (state == S_EXEC) && (opcode == OP_RST_A);
  assign ld[1] = (state == S_EXEC) && (opcode == OP_RST_B);

  rst_pulse_gen #(.RST_CYC(RST_CYC)) u_pulse [NUM_CPU-1:0] (
    .clk   (clk),
    .rst   (rst),
    .load  (ld),
    .pulse (pulse)
  );

  assign reset_A = pulse[0];
  assign reset_B = pulse[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= '0;
      frm               <= '0;
      ack_sel           <= 1'b0;
      bus.com_pop       <= 1'b0;
      bus.tdr_cpuAB     <= '0;
      bus.tf_push_cpuAB <= 1'b0;
      force_swi         <= 1'b0;
      com_swi           <= 1'b0;
      error             <= 1'b0;
    end else begin
      bus.com_pop       <= 1'b0;
      bus.tf_push_cpuAB <= 1'b0;
      case (state)
        // Wait for a whole frame; after that, a shrinking count never aborts.
        S_IDLE: begin
          if (bus.com_count >= CNT_W'(FRAME_LEN)) begin
            idx         <= '0;
            bus.com_pop <= 1'b1;
            state       <= S_POP;
          end
        end
        // com_pop is high this cycle; the head byte is consumed at this edge.
        S_POP: begin
          frm[idx] <= bus.rec_command;
          if ((idx == 3'd0 && bus.rec_command != HDR0) ||
              (idx == 3'd1 && bus.rec_command != HDR1))
            state <= S_IDLE;   // drop just this byte and resync
          else
            state <= S_GAP;
        end
        // Let the UART count settle before the next pop.
        S_GAP: begin
          if (idx == 3'(FRAME_LEN-1)) begin
            state <= S_CHECK;
          end else begin
            idx         <= idx + 3'd1;
            bus.com_pop <= 1'b1;
            state       <= S_POP;
          end
        end
        S_CHECK: begin
          ack_sel <= 1'b0;
          if (frame_good) begin
            state <= S_EXEC;
          end else begin
            error             <= 1'b1;
            bus.tf_push_cpuAB <= 1'b1;
            bus.tdr_cpuAB     <= ACK_ERR;
            state             <= S_ACK;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_MAN_A: begin force_swi <= 1'b1; com_swi <= 1'b0; end
            OP_MAN_B: begin force_swi <= 1'b1; com_swi <= 1'b1; end
            OP_AUTO:  force_swi <= 1'b0;
            default:  ;   // reset opcodes act through ld[]
          endcase
          error             <= 1'b0;
          bus.tf_push_cpuAB <= 1'b1;
          bus.tdr_cpuAB     <= ACK_OK;
          state             <= S_ACK;
        end
        // First ACK byte already on the bus; follow with the opcode echo.
        S_ACK: begin
          if (!ack_sel) begin
            ack_sel           <= 1'b1;
            bus.tf_push_cpuAB <= 1'b1;
            bus.tdr_cpuAB     <= opcode;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
module tb_cmd_frame_ctrl;
  import cmd_frame_ctrl_pkg::*;

  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_swi, com_swi, reset_A, reset_B, error;

  always #5 clk = ~clk;

  cmd_frame_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cmd_frame_ctrl #(
    .CNT_W   (CNT_W),
    .HDR0    (8'hEB),
    .HDR1    (8'h90),
    .RST_CYC (16'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .force_swi (force_swi),
    .com_swi   (com_swi),
    .reset_A   (reset_A),
    .reset_B   (reset_B),
    .error     (error)
  );

  logic [7:0] rxq[$];    // UART receive FIFO model
  logic [7:0] expq[$];   // expected acknowledge bytes
  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc = 0, pop_cnt = 0, last_ack0 = -1;
  int a_rise = -1, a_hi = 0, b_rise = -1, b_hi = 0;
  bit ack_ph = 1'b0, pend_pop = 1'b0;
  logic ra_q = 1'b0, rb_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // FIFO model + output monitor, all on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rxq.delete();
      pend_pop = 1'b0;
      ack_ph   = 1'b0;
    end else begin
      // the strobe seen last negedge was consumed at the posedge in between
      if (pend_pop && rxq.size() != 0) void'(rxq.pop_front());
      pend_pop = bus.com_pop;
      if (bus.com_pop) pop_cnt++;
      if (bus.tf_push_cpuAB) begin
        if (!ack_ph) last_ack0 = cyc;
        ack_ph = ~ack_ph;
        if (expq.size() == 0) chk("ack_unexpected", 32'(bus.tdr_cpuAB), 32'h100);
        else                  chk("ack_byte", 32'(bus.tdr_cpuAB), 32'(expq.pop_front()));
      end
    end
    if (reset_A && !ra_q) begin a_rise = cyc; a_hi = 0; end
    if (reset_A) a_hi++;
    ra_q = reset_A;
    if (reset_B && !rb_q) begin b_rise = cyc; b_hi = 0; end
    if (reset_B) b_hi++;
    rb_q = reset_B;
    bus.com_count   = (rxq.size() > 31) ? CNT_W'(31) : CNT_W'(rxq.size());
    bus.rec_command = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // Queue a frame (b0 in the top byte); predict its ACK when trk is set.
  task automatic send(input logic [63:0] fr, input bit trk);
    logic [7:0] b[8];
    logic [7:0] s;
    for (int i = 0; i < 8; i++) b[i] = fr[63-8*i -: 8];
    s = b[2] + b[3] + b[4] + b[5] + b[6];
    if (trk && b[0] == 8'hEB && b[1] == 8'h90) begin
      expq.push_back((s == b[7] && b[2] >= 8'h01 && b[2] <= 8'h05) ? 8'h5A : 8'hA5);
      expq.push_back(b[2]);
    end
    for (int i = 0; i < 8; i++) rxq.push_back(b[i]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    bus.com_count   = '0;
    bus.rec_command = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({force_swi, com_swi, reset_A, reset_B, error,
                           bus.com_pop, bus.tf_push_cpuAB, bus.tdr_cpuAB}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // manual CPU B
    send(64'hEB90_0200_0000_0002, 1'b1);
    drain("t1_ack_drain");
    chk("t1_levels", 32'({force_swi, com_swi, error}), 32'b110);

    // reset_A pulse: 4 cycles, starting with the first ACK byte (cycle after EXEC)
    send(64'hEB90_0300_0000_0003, 1'b1);
    drain("t2_ack_drain");
    chk("t2_rstA_width", 32'(a_hi), 32'd4);
    chk("t2_rstA_start", 32'(a_rise), 32'(last_ack0));
    chk("t2_rstB_idle",  32'({reset_A, reset_B}), 32'd0);

    // reset_B pulse
    send(64'hEB90_0400_0000_0004, 1'b1);
    drain("t2b_ack_drain");
    chk("t2b_rstB_width", 32'(b_hi), 32'd4);
    chk("t2b_rstB_start", 32'(b_rise), 32'(last_ack0));
    chk("t2b_levels", 32'({force_swi, com_swi, error}), 32'b110);

    // bad checksum: levels untouched, error set; then automatic mode clears it
    send(64'hEB90_0100_0000_0007, 1'b1);
    drain("t3_bad_drain");
    chk("t3_bad_levels", 32'({force_swi, com_swi, error}), 32'b111);
    send(64'hEB90_0500_0000_0005, 1'b1);
    drain("t3_auto_drain");
    chk("t3_auto_levels", 32'({force_swi, com_swi, error}), 32'b010);

    // unknown opcode with a correct checksum is still a bad frame
    send(64'hEB90_0600_0000_0006, 1'b1);
    drain("t3b_op_drain");
    chk("t3b_op_levels", 32'({force_swi, com_swi, error}), 32'b011);

    // junk bytes discarded one at a time, then a good manual-A frame
    rxq.push_back(8'h11);
    rxq.push_back(8'h22);
    send(64'hEB90_0100_0000_0001, 1'b1);
    drain("t4_junk_drain");
    chk("t4_levels", 32'({force_swi, com_swi, error}), 32'b100);
    chk("t4_fifo_empty", 32'(rxq.size()), 32'd0);

    // second-header mismatch: EB accepted, 55 dropped, then EB 90 frame
    rxq.push_back(8'hEB);
    rxq.push_back(8'h55);
    send(64'hEB90_0200_0000_0002, 1'b1);
    drain("t4b_hdr1_drain");
    chk("t4b_levels", 32'({force_swi, com_swi, error}), 32'b110);

    // checksum wrap
    send(64'hEB90_01FF_FF00_00FF, 1'b1);
    drain("t5_wrap_drain");
    chk("t5_wrap_levels", 32'({force_swi, com_swi, error}), 32'b100);
    send(64'hEB90_02FF_FF00_0101, 1'b1);
    drain("t5b_wrap_drain");
    chk("t5b_wrap_levels", 32'({force_swi, com_swi, error}), 32'b110);

    // reset mid-frame: set error first so every level has something to clear
    send(64'hEB90_0200_0000_0000, 1'b1);
    drain("t6_pre_drain");
    chk("t6_pre_levels", 32'({force_swi, com_swi, error}), 32'b111);
    pop_cnt = 0;
    send(64'hEB90_0300_0000_0003, 1'b0);
    begin
      int n = 0;
      while (pop_cnt < 4 && n < 100) begin @(negedge clk); n++; end
    end
    chk("t6_midframe_reached", 32'(pop_cnt >= 4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outs", 32'({force_swi, com_swi, reset_A, reset_B, error,
                            bus.com_pop, bus.tf_push_cpuAB}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(64'hEB90_0200_0000_0002, 1'b1);
    drain("t6_post_drain");
    chk("t6_post_levels", 32'({force_swi, com_swi, error, reset_A}), 32'b1100);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
